morse_element_decoder: RTL
==========================

Name: morse_element_decoder

Overview:
- Parametrised successor to the fixed dot_dash / wait_timer / letter_sm chain in the Morse top level.
- Measures press and gap durations of the debounced key level in board_clk cycles and classifies each press as dot or dash against parametrised thresholds.
- Packs up to MAX_ELEM elements into a letter code and emits it over a valid/ready handshake to the downstream letter lookup and SSD logic.

Parameters:
- CNT_W, 27: width of the duration counter; the counter saturates at 2^CNT_W-1.
- MIN_PRESS, 2_000_000: presses shorter than this many cycles are glitches and are discarded.
- DASH_MIN, 25_000_000: presses of at least this many cycles are dashes; shorter presses are dots.
- LETTER_GAP, 50_000_000: consecutive low cycles that terminate a letter.
- WORD_GAP, 150_000_000: consecutive low cycles that produce a space token (optional feature only).
- MAX_ELEM, 6: maximum elements per letter.
- LEN_W, 3: width of len_out; must satisfy 2^LEN_W > MAX_ELEM.

Ports:
- board_clk  in  1  system clock, 100 MHz.
- Reset  in  1  asynchronous, active-high reset.
- en  in  1  when 0, new presses are not accepted from IDLE.
- dpb  in  1  debounced key level, synchronous to board_clk; 1 = pressed.
- code_out  out  MAX_ELEM  element bits; bit i = element i (first element in bit 0); 1 = dash, 0 = dot; unused bits are 0.
- len_out  out  LEN_W  number of valid elements; 0 only for a space token.
- valid  out  1  code_out, len_out and overflow are valid.
- ready  in  1  consumer accept; transfer occurs when valid && ready are high at a clock edge.
- overflow  out  1  the current letter received more than MAX_ELEM elements.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: Reset is asynchronous, active-high; clock is board_clk. All outputs are 0, state = IDLE, counter = 0, and the element buffer is cleared.
- Reset mid-operation aborts any letter in progress with no output.
- States: IDLE, PRESS, GAP, EMIT, WAIT_REL.
- IDLE:
  - dpb=1 && en=1 -> PRESS with counter=1.
  - Otherwise remain in IDLE.
- PRESS: counter increments (saturating) while dpb=1. On the first dpb=0 sample, with P = counter:
  - P < MIN_PRESS: discard the press; go to GAP if len>0, else IDLE.
  - P >= DASH_MIN: append a dash. MIN_PRESS <= P < DASH_MIN: append a dot.
  - Boundaries: P = DASH_MIN-1 is a dot; P = DASH_MIN is a dash.
  - On append with len < MAX_ELEM: write bit[len] and increment len. With len = MAX_ELEM: drop the element and set overflow (sticky until the letter is transferred).
  - Go to GAP with counter=1.
- GAP: counter increments while dpb=0.
  - dpb=1 -> PRESS with counter=1. The en input is ignored here.
  - Counter reaching LETTER_GAP -> EMIT. valid rises on the edge after the LETTER_GAP-th low sample.
- EMIT:
  - valid=1. code_out, len_out and overflow are held stable until transfer.
  - dpb activity is ignored while in EMIT.
  - On transfer: clear the buffer, len and overflow. valid=0 next cycle. Go to WAIT_REL if dpb=1, else IDLE.
- WAIT_REL: remain until dpb=0, then go to IDLE. The press is not recorded.
- Outputs are registered; code_out, len_out and overflow read 0 whenever valid=0.
- Counter saturation: a press longer than 2^CNT_W-1 cycles is still classified as a dash.

Optional Feature:
- Macro MORSE_WORD_GAP_EN.
- Defined:
  - After a letter transfer with no new press, IDLE keeps counting low cycles from the end of the letter's gap.
  - When the total low count reaches WORD_GAP, emit one space token (len_out=0, code_out=0, valid=1) via EMIT.
  - At most one space token per idle period; a new press re-arms it.
- Undefined: no space token is emitted; the IDLE counter logic is absent.

Test Plan (MIN_PRESS=2, DASH_MIN=8, LETTER_GAP=12, MAX_ELEM=6, WORD_GAP=30, ready=1 unless stated):
- Reset mid-press: dpb=1 for 5 cycles, then pulse Reset -> all outputs 0, busy=0; no valid after release.
- Dot, "E": dpb high 4 cycles, then low -> valid on the edge after the 12th low cycle; len_out=1, code_out=6'b000000; valid low the following cycle.
- Dash-dot-dot, "D": dpb pattern 10 high / 3 low / 7 high / 3 low / 4 high / 12 low -> len_out=3, code_out=6'b000001. A 7-cycle press gives a dot; an 8-cycle press in the same slot gives code_out=6'b000011.
- Glitch: dpb high 1 cycle, then 20 low -> no valid; busy returns to 0.
- Overflow: seven 4-cycle dots separated by 3-cycle gaps, then 12 low -> len_out=6, code_out=0, overflow=1; overflow=0 after transfer.
- Backpressure: ready=0 when valid rises; drive dpb high for 10 cycles -> outputs held stable. Raise ready while dpb=1 -> single transfer, WAIT_REL, no new element recorded.
- With MORSE_WORD_GAP_EN: "E" then dpb low for 30+ cycles -> a second valid with len_out=0; no third token while dpb stays low.

Source files
------------

// File: rtl/morse_element_decoder.sv
// morse_element_decoder: times key presses and gaps, classifies dots/dashes and hands out packed letter codes.
// Optional build macro MORSE_WORD_GAP_EN adds a space token (len_out=0) after a long idle low period.
module morse_element_decoder #(
    parameter int CNT_W      = 27,
    parameter int MIN_PRESS  = 2_000_000,
    parameter int DASH_MIN   = 25_000_000,
    parameter int LETTER_GAP = 50_000_000,
    parameter int WORD_GAP   = 150_000_000,
    parameter int MAX_ELEM   = 6,
    parameter int LEN_W      = 3
) (
    input  logic                board_clk,
    input  logic                Reset,
    input  logic                en,
    input  logic                dpb,
    output logic [MAX_ELEM-1:0] code_out,
    output logic [LEN_W-1:0]    len_out,
    output logic                valid,
    input  logic                ready,
    output logic                overflow,
    output logic                busy
);
    typedef enum logic [2:0] {IDLE, PRESS, GAP, EMIT, WAIT_REL} state_t;

    if ((2 ** LEN_W) <= MAX_ELEM || WORD_GAP < LETTER_GAP || DASH_MIN < MIN_PRESS) begin : g_param_check
        $error("morse_element_decoder: inconsistent parameters");
    end

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [MAX_ELEM-1:0] code_buf;
    logic [LEN_W-1:0]    len;
    logic                ovf;
    logic [CNT_W-1:0]    cnt_sat;
    logic [31:0]         cnt32;
    logic                len_full;
`ifdef MORSE_WORD_GAP_EN
    logic                arm;
    logic [31:0]         wcnt;
`endif

    assign cnt_sat  = (&cnt) ? cnt : cnt + ONE;
    assign cnt32    = 32'(cnt);
    assign len_full = 32'(len) >= 32'(MAX_ELEM);

    // Element FSM: duration counting, classification, letter packing and output handshake.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            code_buf <= '0;
            len      <= '0;
            ovf      <= 1'b0;
            code_out <= '0;
            len_out  <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
            arm      <= 1'b0;
            wcnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (dpb && en) begin
                        state <= PRESS;
                        cnt   <= ONE;
                        busy  <= 1'b1;
`ifdef MORSE_WORD_GAP_EN
                        arm   <= 1'b0;
                    end else if (dpb) begin
                        arm <= 1'b0;
                    end else if (arm) begin
                        if (wcnt + 32'd1 >= 32'(WORD_GAP)) begin
                            state <= EMIT;
                            valid <= 1'b1;
                            busy  <= 1'b1;
                            arm   <= 1'b0;
                        end else begin
                            wcnt <= wcnt + 32'd1;
                        end
`endif
                    end
                end
                PRESS: begin
                    if (dpb) begin
                        cnt <= cnt_sat;
                    end else begin
                        cnt <= ONE;
                        if (cnt32 < 32'(MIN_PRESS)) begin
                            state <= (len == '0) ? IDLE : GAP;
                            busy  <= (len != '0);
                        end else begin
                            state <= GAP;
                            if (len_full) begin
                                ovf <= 1'b1;
                            end else begin
                                code_buf[len] <= (cnt32 >= 32'(DASH_MIN));
                                len           <= len + LEN_W'(1);
                            end
                        end
                    end
                end
                GAP: begin
                    if (dpb) begin
                        state <= PRESS;
                        cnt   <= ONE;
                    end else begin
                        cnt <= cnt_sat;
                        if (cnt32 + 32'd1 >= 32'(LETTER_GAP)) begin
                            state    <= EMIT;
                            valid    <= 1'b1;
                            code_out <= code_buf;
                            len_out  <= len;
                            overflow <= ovf;
                        end
                    end
                end
                EMIT: begin
                    if (!dpb) cnt <= cnt_sat;
                    if (ready) begin
                        valid    <= 1'b0;
                        code_out <= '0;
                        len_out  <= '0;
                        overflow <= 1'b0;
                        code_buf <= '0;
                        len      <= '0;
                        ovf      <= 1'b0;
                        state    <= dpb ? WAIT_REL : IDLE;
                        busy     <= dpb;
`ifdef MORSE_WORD_GAP_EN
                        arm      <= !dpb && (len_out != '0);
                        wcnt     <= cnt32 + 32'd1;
`endif
                    end
                end
                WAIT_REL: begin
                    if (!dpb) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
